// File: rtl/stripe_scheduler_pkg.sv
// Shared definitions for the column-block scheduler: state encoding and default sizes.
// CalcLine and Frameblock import the same ID_W default so draw_id widths agree.
package stripe_scheduler_pkg;

  localparam int NUM_BLOCKS_DEFAULT = 80;  // 320 px / 4-px column blocks
  localparam int ID_W_DEFAULT       = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FLUSH,
    ST_SWAP
  } state_t;

endpackage

// File: rtl/stripe_scheduler_if.sv
// Handshake bundle between the stripe scheduler and PreCalc, the triangle FIFOs,
// CalcLine and Frameblock. The master modport is the scheduler side.
interface stripe_scheduler_if
  import stripe_scheduler_pkg::*;
#(
  parameter int ID_W = ID_W_DEFAULT
);

  logic            frame_start;
  logic            precalc_done;
  logic            a_empty;
  logic            b_empty;
  logic            a_pull;
  logic            b_pull;
  logic            a_push;
  logic            b_push;
  logic            cl_empty;
  logic            cl_pull;
  logic            cl_push;
  logic            cl_idle;
  logic [ID_W-1:0] draw_id;
  logic            draw_next;
  logic            draw_ready;
  logic            src_sel;
  logic            frame_done;
  logic            err;

  modport master (
    input  frame_start, precalc_done, a_empty, b_empty,
           cl_pull, cl_push, cl_idle, draw_ready,
    output a_pull, b_pull, a_push, b_push, cl_empty,
           draw_id, draw_next, src_sel, frame_done, err
  );

  modport slave (
    output frame_start, precalc_done, a_empty, b_empty,
           cl_pull, cl_push, cl_idle, draw_ready,
    input  a_pull, b_pull, a_push, b_push, cl_empty,
           draw_id, draw_next, src_sel, frame_done, err
  );

endinterface

// File: rtl/stripe_scheduler.sv
// Walks CalcLine across the column blocks of a frame, ping-ponging the two
// triangle FIFOs and flushing each finished block to Frameblock.
module stripe_scheduler
  import stripe_scheduler_pkg::*;
#(
  parameter int NUM_BLOCKS = NUM_BLOCKS_DEFAULT,
  parameter int ID_W       = ID_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  stripe_scheduler_if.master bus
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_BLOCKS - 1);

  state_t          state_reg;
  logic [ID_W-1:0] draw_id_reg;
  logic            src_sel_reg;
  logic            err_reg;
  logic            frame_done_reg;

  logic src_empty;
  logic sink_empty;
  logic block_done;

  assign src_empty  = src_sel_reg ? bus.b_empty : bus.a_empty;
  assign sink_empty = src_sel_reg ? bus.a_empty : bus.b_empty;

  // Block 0 must also wait for PreCalc: FIFO A may be empty only momentarily.
  assign block_done = bus.cl_idle & src_empty & ~bus.cl_push &
                      ((draw_id_reg != '0) | bus.precalc_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      draw_id_reg    <= '0;
      src_sel_reg    <= 1'b0;
      err_reg        <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.frame_start) begin
            err_reg   <= 1'b0;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (block_done) state_reg <= ST_DRAIN;
        end
        // Second look catches CalcLine leaving IDLE for PULL1 right after the first.
        ST_DRAIN: begin
          state_reg <= block_done ? ST_FLUSH : ST_RUN;
        end
        ST_FLUSH: begin
          if (bus.draw_ready) state_reg <= ST_SWAP;
        end
        ST_SWAP: begin
          if (draw_id_reg == LAST_ID) begin
            frame_done_reg <= 1'b1;
            if (!sink_empty) err_reg <= 1'b1;
            draw_id_reg    <= '0;
            src_sel_reg    <= 1'b0;
            state_reg      <= ST_IDLE;
          end else begin
            draw_id_reg <= draw_id_reg + ID_W'(1);
            src_sel_reg <= ~src_sel_reg;
            state_reg   <= ST_RUN;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.cl_empty   = (state_reg == ST_RUN) ? src_empty : 1'b1;
  assign bus.draw_next  = (state_reg == ST_FLUSH) & bus.draw_ready;

  assign bus.a_pull     = bus.cl_pull & ~src_sel_reg;
  assign bus.b_pull     = bus.cl_pull &  src_sel_reg;
  assign bus.a_push     = bus.cl_push &  src_sel_reg;
  assign bus.b_push     = bus.cl_push & ~src_sel_reg;

  assign bus.draw_id    = draw_id_reg;
  assign bus.src_sel    = src_sel_reg;
  assign bus.err        = err_reg;
  assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_stripe_scheduler.sv
// Random-stimulus bench for stripe_scheduler, checked every cycle against a
// block-level reference model, plus a directed empty-frame timing run.
module tb_stripe_scheduler;
  import stripe_scheduler_pkg::*;

  localparam int NB = NUM_BLOCKS_DEFAULT;
  localparam int IW = ID_W_DEFAULT;

  // Model phases of one column block
  localparam int P_IDLE  = 0;
  localparam int P_WORK  = 1;
  localparam int P_CHECK = 2;
  localparam int P_FLUSH = 3;
  localparam int P_SWAP  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stripe_scheduler_if #(.ID_W(IW)) bus ();

  stripe_scheduler #(.NUM_BLOCKS(NB), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int frames   = 0;

  // Reference model state
  int m_phase;
  int m_block;
  bit m_err;
  bit m_fdone;

  // Directed-run observation
  bit recording = 1'b0;
  int dn_cyc[$];
  int dn_id[$];
  int fd_cyc = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_block = 0;
    m_err   = 1'b0;
    m_fdone = 1'b0;
  endtask

  // One clock edge of the block-level rules, using the inputs held during the cycle.
  task automatic model_edge();
    bit swapped, src_e, sink_e, finished;
    if (rst) begin
      model_reset();
      return;
    end
    swapped  = (m_block % 2) == 1;
    src_e    = swapped ? bus.b_empty : bus.a_empty;
    sink_e   = swapped ? bus.a_empty : bus.b_empty;
    finished = bus.cl_idle && src_e && !bus.cl_push && (m_block != 0 || bus.precalc_done);
    m_fdone  = 1'b0;
    case (m_phase)
      P_IDLE:  if (bus.frame_start) begin m_err = 1'b0; m_phase = P_WORK; end
      P_WORK:  if (finished) m_phase = P_CHECK;
      P_CHECK: m_phase = finished ? P_FLUSH : P_WORK;
      P_FLUSH: if (bus.draw_ready) m_phase = P_SWAP;
      default: begin
        if (m_block == NB - 1) begin
          m_fdone = 1'b1;
          if (!sink_e) m_err = 1'b1;
          m_block = 0;
          m_phase = P_IDLE;
        end else begin
          m_block++;
          m_phase = P_WORK;
        end
      end
    endcase
  endtask

  task automatic step();
    bit swapped, exp_cl_empty;
    @(negedge clk);
    swapped      = (m_block % 2) == 1;
    exp_cl_empty = (m_phase == P_WORK) ? (swapped ? bus.b_empty : bus.a_empty) : 1'b1;
    check("draw_id",    32'(bus.draw_id),    32'(m_block));
    check("src_sel",    32'(bus.src_sel),    32'(swapped));
    check("err",        32'(bus.err),        32'(m_err));
    check("frame_done", 32'(bus.frame_done), 32'(m_fdone));
    check("draw_next",  32'(bus.draw_next),  32'(m_phase == P_FLUSH && bus.draw_ready));
    check("cl_empty",   32'(bus.cl_empty),   32'(exp_cl_empty));
    check("a_pull",     32'(bus.a_pull),     32'(bus.cl_pull && !swapped));
    check("b_pull",     32'(bus.b_pull),     32'(bus.cl_pull && swapped));
    check("a_push",     32'(bus.a_push),     32'(bus.cl_push && swapped));
    check("b_push",     32'(bus.b_push),     32'(bus.cl_push && !swapped));
    if (recording && bus.draw_next) begin
      dn_cyc.push_back(cyc);
      dn_id.push_back(int'(bus.draw_id));
    end
    if (bus.frame_done) begin
      frames++;
      if (recording && fd_cyc < 0) fd_cyc = cyc;
      $display("frame %0d complete at cycle %0d err=%0d", frames, cyc, bus.err);
    end
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic set_quiet();
    bus.frame_start  = 1'b0;
    bus.precalc_done = 1'b1;
    bus.a_empty      = 1'b1;
    bus.b_empty      = 1'b1;
    bus.cl_pull      = 1'b0;
    bus.cl_push      = 1'b0;
    bus.cl_idle      = 1'b1;
    bus.draw_ready   = 1'b1;
  endtask

  initial begin
    int c0;
    bit pc_level;
    set_quiet();
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    cyc = 1;
    step();
    step();
    rst = 1'b0;
    step();

    // Directed empty frame: one flush every 4 cycles, frame_done after the last SWAP
    recording = 1'b1;
    c0 = cyc;
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    repeat (4 * NB + 8) step();
    recording = 1'b0;
    check("empty_frame_strobes", 32'(dn_cyc.size()), 32'(NB));
    for (int k = 0; k < dn_cyc.size() && k < NB; k++) begin
      check("empty_frame_id",    32'(dn_id[k]),  32'(k));
      check("empty_frame_cycle", 32'(dn_cyc[k]), 32'(c0 + 3 + 4 * k));
    end
    check("empty_frame_done_cycle", 32'(fd_cyc), 32'(c0 + 4 * NB + 1));
    check("empty_frame_err", 32'(bus.err), 32'(0));

    // Randomized traffic: backpressure, drain races, PreCalc gating, stale sink, resets
    pc_level = 1'b0;
    for (int i = 0; i < 16000; i++) begin
      if ($urandom_range(29) == 0) pc_level = ~pc_level;
      bus.frame_start  = ($urandom_range(39) == 0);
      bus.precalc_done = pc_level;
      bus.a_empty      = ($urandom_range(9) < 8);
      bus.b_empty      = ($urandom_range(9) < 8);
      bus.cl_idle      = ($urandom_range(9) < 8);
      bus.cl_push      = ($urandom_range(9) == 0);
      bus.cl_pull      = ($urandom_range(3) == 0);
      bus.draw_ready   = ($urandom_range(9) < 7);
      rst              = ($urandom_range(2999) == 0);
      step();
    end
    rst = 1'b0;
    set_quiet();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
